// File: rtl/video_sprite_engine.sv
// Sprite engine: copies a 2^AW x 8 sprite from a source ROM during blanking and
// overlays it (RGB332 expanded to RGB565, integer-scaled) on an x+y background.
// Latency: pixel path is 2 cycles from x/y/den to color/color_den.
// Backpressure: none; the copy pauses while den=1. Optional: SPRITE_TRANSPARENT_EN.
module video_sprite_engine #(
    parameter int          SPR_W_LOG2 = 5,
    parameter int          SPR_H_LOG2 = 5,
    parameter int          SCALE_LOG2 = 2,
    parameter int          START_X    = 100,
    parameter int          START_Y    = 50,
    parameter logic [7:0]  KEY        = 8'h00,
    localparam int         AW         = SPR_W_LOG2 + SPR_H_LOG2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [15:0]   x,
    input  logic [15:0]   y,
    input  logic          den,
    input  logic          load,
    output logic [AW-1:0] src_addr,
    input  logic [7:0]    src_data,
    output logic          busy,
    output logic          done,
    output logic [15:0]   color,
    output logic          color_den
);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

    localparam logic [AW-1:0] LAST = '1;
    localparam logic [15:0]   X0   = 16'(START_X);
    localparam logic [15:0]   X1   = 16'(START_X + ((2 ** SPR_W_LOG2) << SCALE_LOG2));
    localparam logic [15:0]   Y0   = 16'(START_Y);
    localparam logic [15:0]   Y1   = 16'(START_Y + ((2 ** SPR_H_LOG2) << SCALE_LOG2));

    state_t          r_state, w_next;
    logic [AW-1:0]   r_src_addr;
    logic            r_all_iss;   // last address already issued; stop walking
    logic            r_wr_vld;
    logic [AW-1:0]   r_wr_addr;
    logic            w_issue;

    logic [7:0]      r_buf [0:(2**AW)-1];
    logic [7:0]      r_s1_pix;
    logic            r_s1_vld, r_s1_in;
    logic [15:0]     r_s1_bg;
    logic [15:0]     r_color;
    logic            r_cden;

    logic            w_in;
    logic [15:0]     w_dx, w_dy, w_bg;
    logic [AW-1:0]   w_rd_addr;
    logic [15:0]     w_exp, w_pix;
    logic            w_key;
    logic            w_unused;

    // Copy FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Copy FSM next state and status outputs; load only matters in IDLE.
    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: if (load) w_next = S_COPY;
            S_COPY: begin
                busy = 1'b1;
                if (r_wr_vld && (r_wr_addr == LAST)) w_next = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Addresses are only issued during blanking, so active video stalls the copy.
    assign w_issue = (r_state == S_COPY) && !den && !r_all_iss;

    // Source address walk and one-cycle-delayed write qualifier.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_addr <= '0;
            r_all_iss  <= 1'b0;
            r_wr_vld   <= 1'b0;
            r_wr_addr  <= '0;
        end else begin
            r_wr_vld  <= w_issue;
            r_wr_addr <= r_src_addr;
            if ((r_state == S_IDLE) && load) begin
                r_src_addr <= '0;
                r_all_iss  <= 1'b0;
            end else if (w_issue) begin
                if (r_src_addr == LAST) r_all_iss  <= 1'b1;
                else                    r_src_addr <= r_src_addr + 1'b1;
            end
        end
    end

    assign src_addr = r_src_addr;

    // Window test and scaled buffer address, all at 16-bit width.
    assign w_in      = (x >= X0) && (x < X1) && (y >= Y0) && (y < Y1);
    assign w_dx      = x - X0;
    assign w_dy      = y - Y0;
    assign w_bg      = x + y;
    assign w_rd_addr = {w_dy[SCALE_LOG2 +: SPR_H_LOG2], w_dx[SCALE_LOG2 +: SPR_W_LOG2]};

    // Sprite buffer: not reset; a same-address read during a write sees old data.
    always_ff @(posedge clk) begin
        if (r_wr_vld) r_buf[r_wr_addr] <= src_data;
        r_s1_pix <= r_buf[w_rd_addr];
    end

    // Pixel stage 1: register window flag, background and display enable.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_vld <= 1'b0;
            r_s1_in  <= 1'b0;
            r_s1_bg  <= '0;
        end else begin
            r_s1_vld <= den;
            r_s1_in  <= w_in;
            r_s1_bg  <= w_bg;
        end
    end

    assign w_exp = {r_s1_pix[7:5], r_s1_pix[7:6],
                    r_s1_pix[4:2], r_s1_pix[4:2],
                    r_s1_pix[1:0], r_s1_pix[1:0], r_s1_pix[1]};

`ifdef SPRITE_TRANSPARENT_EN
    assign w_key = (r_s1_pix == KEY);
`else
    assign w_key = 1'b0;
`endif

    assign w_pix = !r_s1_vld              ? 16'h0000 :
                   (r_s1_in && !w_key)    ? w_exp    : r_s1_bg;

    // Pixel stage 2: final colour, forced black during blanking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_color <= '0;
            r_cden  <= 1'b0;
        end else begin
            r_color <= w_pix;
            r_cden  <= r_s1_vld;
        end
    end

    assign color     = r_color;
    assign color_den = r_cden;

    // Low offset bits and high bits beyond the sprite size carry no information.
    assign w_unused = ^{w_dx, w_dy, KEY};

endmodule

// File: tb/tb_video_sprite_engine.sv
// Bench for video_sprite_engine: random pixel stimulus against a scoreboard fed
// by a behavioural model, plus directed copy, pause and reset-abort sequences.
// Checks run on a monitor decoupled from the stimulus process.
module tb_video_sprite_engine;

    localparam int AW = 10;

    logic          clk, rst, den, load, busy, done, color_den;
    logic [15:0]   x, y, color;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_data;

    logic [7:0]    rom  [1024];
    logic [7:0]    mbuf [1024];

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        logic [15:0] col;
        logic        cden;
    } exp_t;
    exp_t sb[$];

    video_sprite_engine dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .den(den), .load(load),
        .src_addr(src_addr), .src_data(src_data), .busy(busy), .done(done),
        .color(color), .color_den(color_den)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous source ROM: data valid one cycle after address.
    always @(posedge clk) src_data <= rom[src_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rgb565(input int d);
        int r3, g3, b2;
        r3 = d / 32;
        g3 = (d / 4) % 8;
        b2 = d % 4;
        return (r3 * 4 + r3 / 2) * 2048 + (g3 * 8 + g3) * 32 + (b2 * 8 + b2 * 2 + b2 / 2);
    endfunction

    function automatic logic [15:0] model_px(input int xi, input int yi, input logic dd);
        int bg, d;
        bg = (xi + yi) % 65536;
        if (!dd) return 16'h0000;
        if (xi >= 100 && xi < 228 && yi >= 50 && yi < 178) begin
            d = int'(mbuf[((yi - 50) / 4) * 32 + (xi - 100) / 4]);
`ifdef SPRITE_TRANSPARENT_EN
            if (d == 0) return 16'(bg);
`endif
            return 16'(rgb565(d));
        end
        return 16'(bg);
    endfunction

    task automatic drive_px(input logic [15:0] xx, input logic [15:0] yy, input logic dd);
        exp_t e;
        x = xx;
        y = yy;
        den = dd;
        e.due  = cyc + 2;
        e.col  = model_px(int'(xx), int'(yy), dd);
        e.cden = dd;
        sb.push_back(e);
        tick();
    endtask

    // Monitor: compare every due scoreboard entry against the DUT output.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            if (e.due < cyc) chk("sb_late", 32'(e.due), 32'(cyc));
            else begin
                chk("color_den", 32'(color_den), 32'(e.cden));
                chk("color", 32'(color), 32'(e.col));
            end
        end
    end

    task automatic drain();
        den = 1'b0;
        repeat (3) tick();
        chk("sb_drain", 32'(sb.size()), 0);
    endtask

    task automatic rand_px(input int n);
        logic [15:0] xx, yy;
        for (int i = 0; i < n; i++) begin
            xx = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(90, 240));
            yy = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(40, 190));
            drive_px(xx, yy, $urandom_range(0, 3) != 0);
        end
    endtask

    // Full copy with an optional 50-cycle den=1 pause starting at frz.
    task automatic do_copy(input int frz);
        int exp_a, ndone, done_at, bad_walk, j, pause;
        pause = (frz >= 0) ? 50 : 0;
        den = 1'b0;
        load = 1'b1;
        chk("busy_before_load", 32'(busy), 0);
        tick();
        load = 1'b0;
        chk("busy_rise", 32'(busy), 1);
        chk("addr_start", 32'(src_addr), 0);
        exp_a = 0; ndone = 0; done_at = -1; bad_walk = 0;
        for (j = 0; j < 3000 && busy; j++) begin
            if (int'(src_addr) != exp_a) bad_walk++;
            den = (frz >= 0 && j >= frz && j < frz + 50);
            if (!den && exp_a < 1023) exp_a++;
            tick();
            if (done) begin
                ndone++;
                done_at = j + 1;
            end
        end
        den = 1'b0;
        chk("copy_timeout", 32'(busy), 0);
        chk("addr_walk_bad", 32'(bad_walk), 0);
        chk("done_pulses", 32'(ndone), 1);
        chk("done_window", 32'(done_at >= 1020 + pause && done_at <= 1032 + pause), 1);
        chk("addr_end", 32'(src_addr), 1023);
        for (int i = 0; i < 1024; i++) mbuf[i] = rom[i];
    endtask

    initial begin
        int r, c, k, nd;
        rst = 1'b0; load = 1'b0; den = 1'b0; x = '0; y = '0;
        for (int i = 0; i < 1024; i++) rom[i] = 8'(i);
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_addr", 32'(src_addr), 0);
        chk("rst_color", 32'(color), 0);
        chk("rst_cden", 32'(color_den), 0);
        repeat (2) tick();
        rst = 1'b1;
        repeat (2) tick();

        // Uninterrupted copy of addr-pattern ROM.
        do_copy(-1);
        drain();

        // Directed pixels including window edges and 16-bit wrap of background.
        drive_px(16'd104, 16'd54, 1'b1);
        drive_px(16'd99, 16'd60, 1'b1);
        drive_px(16'd99, 16'd60, 1'b0);
        drive_px(16'd100, 16'd50, 1'b1);
        drive_px(16'd227, 16'd177, 1'b1);
        drive_px(16'd228, 16'd100, 1'b1);
        drive_px(16'd150, 16'd178, 1'b1);
        drive_px(16'd100, 16'd49, 1'b1);
        drive_px(16'hFFF0, 16'h0020, 1'b1);
        rand_px(300);
        drain();

        // Copy of random data with a pause in the middle, then full readback.
        for (int i = 0; i < 1024; i++) rom[i] = 8'($urandom);
        rom[5] = 8'h00;
        do_copy(200);
        drain();
        for (int i = 0; i < 1024; i++) begin
            r = i / 32;
            c = i % 32;
            drive_px(16'(100 + c * 4 + $urandom_range(0, 3)), 16'(50 + r * 4 + $urandom_range(0, 3)), 1'b1);
        end
        drain();

        // Reset in the middle of a copy.
        load = 1'b1;
        tick();
        load = 1'b0;
        for (k = 0; k < 2000 && src_addr != 10'd300; k++) tick();
        chk("abort_reach_300", 32'(src_addr), 300);
        #2 rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_addr", 32'(src_addr), 0);
        chk("abort_cden", 32'(color_den), 0);
        tick();
        rst = 1'b1;
        nd = 0;
        for (int i = 0; i < 1100; i++) begin
            tick();
            if (done || busy) nd++;
        end
        chk("abort_no_done", 32'(nd), 0);
        do_copy(-1);
        drain();
        rand_px(300);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
